// File: rtl/tff_mod_counter_pkg.sv
// Shared definitions for the sequential-lab counters: direction encoding,
// operation select and the modulo next-count helper.
package tff_mod_counter_pkg;

  // Arithmetic is done one bit wider than the widest supported counter (32 bits).
  localparam int unsigned ARITH_W = 33;
  typedef logic [ARITH_W-1:0] arith_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  function automatic arith_t step_count(input arith_t cnt, input logic dir, input arith_t modulus);
    arith_t last;
    arith_t nxt;
    last = modulus - arith_t'(1);
    if (dir == DIR_DOWN) begin
      if (cnt == arith_t'(0)) nxt = last;
      else                    nxt = cnt - arith_t'(1);
    end else begin
      if (cnt == last) nxt = arith_t'(0);
      else             nxt = cnt + arith_t'(1);
    end
    return nxt;
  endfunction

  function automatic op_e select_op(input logic clear, input logic load, input logic en);
    op_e op;
    if (clear)     op = OP_CLEAR;
    else if (load) op = OP_LOAD;
    else if (en)   op = OP_COUNT;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/tff_mod_counter_cell.sv
// Single T flip-flop storage cell: toggles when t is high, otherwise holds.
// Asynchronous active-low reset loads the per-cell init value.
module tff_cell #(
  parameter logic INIT = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic t,
  output logic q
);

  logic q_r;

  // T flip-flop state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_r <= INIT;
    end else if (t) begin
      q_r <= ~q_r;
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MODULUS up/down counter built from WIDTH T flip-flop cells, with
// clear > load > count priority, terminal count, wrap and load-error pulses.
module tff_mod_counter
  import tff_mod_counter_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  // MOD_X is one bit wider so MODULUS == 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_X    = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] count_s;
  logic [WIDTH-1:0] step_s;
  logic [WIDTH-1:0] next_s;
  logic [WIDTH-1:0] toggle_s;
  op_e              op_s;
  logic             load_ok_s;
  logic             at_bound_s;
  logic             wrap_next_s;
  logic             load_err_next_s;
  logic             wrap_r;
  logic             load_err_r;

  assign step_s     = WIDTH'(step_count(arith_t'(count_s), up, arith_t'(MODULUS)));
  assign load_ok_s  = ({1'b0, load_val} < MOD_X);
  assign at_bound_s = (up == DIR_UP) ? (count_s == LAST_VAL) : (count_s == '0);

  // Next-count selection and status pulse decode.
  always_comb begin
    op_s            = select_op(clear, load, en);
    next_s          = count_s;
    wrap_next_s     = 1'b0;
    load_err_next_s = 1'b0;
    case (op_s)
      OP_CLEAR: begin
        next_s = '0;
      end
      OP_LOAD: begin
        if (load_ok_s) begin
          next_s = load_val;
        end else begin
          next_s          = LAST_VAL;
          load_err_next_s = 1'b1;
        end
      end
      OP_COUNT: begin
        next_s      = step_s;
        wrap_next_s = at_bound_s;
      end
      OP_HOLD: begin
        next_s = count_s;
      end
      default: begin
        next_s = count_s;
      end
    endcase
  end

  // Each cell flips exactly the bits that differ between now and next.
  assign toggle_s = count_s ^ next_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(
      .INIT (INIT_VAL[i])
    ) u_cell (
      .clock (clock),
      .reset (reset),
      .t     (toggle_s[i]),
      .q     (count_s[i])
    );
  end

  // Registered one-cycle status pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      wrap_r     <= wrap_next_s;
      load_err_r <= load_err_next_s;
    end
  end

  assign count    = count_s;
  assign tc       = en & ~clear & ~load & at_bound_s;
  assign wrap     = wrap_r;
  assign load_err = load_err_r;

  tff_mod_counter_chk #(
    .WIDTH     (WIDTH),
    .MODULUS   (MODULUS),
    .RESET_VAL (RESET_VAL)
  ) u_chk (
    .clock (clock)
  );

endmodule

// Parameter legality checker: an illegal configuration stops simulation.
module tff_mod_counter_chk #(
  parameter int WIDTH     = 4,
  parameter int MODULUS   = 16,
  parameter int RESET_VAL = 0
) (
  input logic clock
);

  localparam longint CAP       = longint'(1) << WIDTH;
  localparam bit     PARAMS_OK = (WIDTH >= 1) && (WIDTH <= 32) && (MODULUS >= 2) &&
                                 (longint'(MODULUS) <= CAP) && (RESET_VAL >= 0) &&
                                 (RESET_VAL < MODULUS);

  a_params_legal: assert property (@(posedge clock) PARAMS_OK)
    else $fatal(1, "tff_mod_counter: illegal WIDTH/MODULUS/RESET_VAL");

endmodule

// File: tb/tb_tff_mod_counter.sv
// Randomised and directed bench for tff_mod_counter against an integer-arithmetic
// reference model; instance A is WIDTH=4/MODULUS=10, instance B is 3/8/RESET_VAL=5.
module tb_tff_mod_counter;

  localparam int MA = 10;
  localparam int MB = 8;

  logic       clk = 1'b0;
  logic       a_rst, a_en, a_up, a_load, a_clear;
  logic [3:0] a_lv, a_count;
  logic       a_tc, a_wrap, a_err;
  logic       b_rst, b_en, b_up, b_load, b_clear;
  logic [2:0] b_lv, b_count;
  logic       b_tc, b_wrap, b_err;

  int tests = 0;
  int fails = 0;
  int ma = 0;
  int mb = 5;

  always #5 clk = ~clk;

  tff_mod_counter #(.WIDTH(4), .MODULUS(MA), .RESET_VAL(0)) dut_a (
    .clock(clk), .reset(a_rst), .en(a_en), .up(a_up), .load(a_load), .load_val(a_lv),
    .clear(a_clear), .count(a_count), .tc(a_tc), .wrap(a_wrap), .load_err(a_err)
  );

  tff_mod_counter #(.WIDTH(3), .MODULUS(MB), .RESET_VAL(5)) dut_b (
    .clock(clk), .reset(b_rst), .en(b_en), .up(b_up), .load(b_load), .load_val(b_lv),
    .clear(b_clear), .count(b_count), .tc(b_tc), .wrap(b_wrap), .load_err(b_err)
  );

  // Reference model: plain modular arithmetic over the priority rules.
  function automatic int ref_next(int c, int m, bit en_i, bit up_i, bit ld_i, bit clr_i, int lv);
    if (clr_i) return 0;
    if (ld_i)  return (lv < m) ? lv : m - 1;
    if (en_i)  return up_i ? (c + 1) % m : (c + m - 1) % m;
    return c;
  endfunction

  function automatic bit ref_tc(int c, int m, bit en_i, bit up_i, bit ld_i, bit clr_i);
    return en_i && !ld_i && !clr_i && (up_i ? (c == m - 1) : (c == 0));
  endfunction

  // A wrap is an enabled count step whose result moved against the direction.
  function automatic bit ref_wrap(int c, int n, bit en_i, bit up_i, bit ld_i, bit clr_i);
    return en_i && !ld_i && !clr_i && (up_i ? (n < c) : (n > c));
  endfunction

  function automatic bit ref_err(int m, bit ld_i, bit clr_i, int lv);
    return !clr_i && ld_i && (lv >= m);
  endfunction

  task automatic drive_a(bit en_i, bit up_i, bit ld_i, bit clr_i, int lv);
    a_en = en_i; a_up = up_i; a_load = ld_i; a_clear = clr_i; a_lv = 4'(lv);
  endtask

  task automatic drive_b(bit en_i, bit up_i, bit ld_i, bit clr_i, int lv);
    b_en = en_i; b_up = up_i; b_load = ld_i; b_clear = clr_i; b_lv = 3'(lv);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_rst = 1'b0; b_rst = 1'b0;
    drive_a(0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0);
    #12;
    tests++;
    if (a_count !== 4'd0 || a_wrap !== 1'b0 || a_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_a: got count=%0d wrap=%0b err=%0b, want 0 0 0", a_count, a_wrap, a_err);
    end
    tests++;
    if (b_count !== 3'd5 || b_wrap !== 1'b0 || b_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_b: got count=%0d wrap=%0b err=%0b, want 5 0 0", b_count, b_wrap, b_err);
    end
    @(negedge clk);
    a_rst = 1'b1; b_rst = 1'b1;
    ma = 0; mb = 5;
    tick;
    tests++;
    if (a_count !== 4'(ma) || b_count !== 3'(mb)) begin
      fails++;
      $display("FAIL reset_release: got a=%0d b=%0d, want a=%0d b=%0d", a_count, b_count, ma, mb);
    end
  endtask

  // Shared body of the directed A tables: apply one input set, check tc, clock, check outputs.
  task automatic test_table_a(string name, int n, int en_t[], int up_t[], int ld_t[], int clr_t[], int lv_t[]);
    int nxt;
    bit exp_tc, exp_w, exp_e;
    for (int k = 0; k < n; k++) begin
      drive_a(en_t[k][0], up_t[k][0], ld_t[k][0], clr_t[k][0], lv_t[k]);
      #1;
      exp_tc = ref_tc(ma, MA, en_t[k][0], up_t[k][0], ld_t[k][0], clr_t[k][0]);
      tests++;
      if (a_tc !== exp_tc) begin
        fails++;
        $display("FAIL %s_tc step %0d: got %0b, want %0b (count=%0d)", name, k, a_tc, exp_tc, ma);
      end
      nxt   = ref_next(ma, MA, en_t[k][0], up_t[k][0], ld_t[k][0], clr_t[k][0], lv_t[k]);
      exp_w = ref_wrap(ma, nxt, en_t[k][0], up_t[k][0], ld_t[k][0], clr_t[k][0]);
      exp_e = ref_err(MA, ld_t[k][0], clr_t[k][0], lv_t[k]);
      tick;
      tests++;
      if (a_count !== 4'(nxt) || a_wrap !== exp_w || a_err !== exp_e) begin
        fails++;
        $display("FAIL %s step %0d: got count=%0d wrap=%0b err=%0b, want count=%0d wrap=%0b err=%0b",
                 name, k, a_count, a_wrap, a_err, nxt, exp_w, exp_e);
      end
      ma = nxt;
    end
  endtask

  task automatic test_count_up;
    int en_t[] = '{1,1,1,1,1,1,1,1,1,1,1,1};
    int up_t[] = '{1,1,1,1,1,1,1,1,1,1,1,1};
    int z_t[]  = '{0,0,0,0,0,0,0,0,0,0,0,0};
    test_table_a("count_up", 12, en_t, up_t, z_t, z_t, z_t);
    tests++;
    if (a_count !== 4'd2) begin
      fails++;
      $display("FAIL count_up_end: got %0d, want 2", a_count);
    end
  endtask

  task automatic test_count_down;
    int en_t[]  = '{0, 1, 1, 1, 0};
    int up_t[]  = '{0, 0, 0, 0, 0};
    int ld_t[]  = '{1, 0, 0, 0, 0};
    int clr_t[] = '{0, 0, 0, 0, 0};
    int lv_t[]  = '{1, 0, 0, 0, 0};
    test_table_a("count_down", 5, en_t, up_t, ld_t, clr_t, lv_t);
  endtask

  task automatic test_load;
    int en_t[]  = '{0, 0, 0, 0, 0};
    int up_t[]  = '{1, 1, 1, 1, 1};
    int ld_t[]  = '{1, 1, 0, 1, 1};
    int clr_t[] = '{0, 0, 0, 0, 0};
    int lv_t[]  = '{7, 12, 0, 15, 10};
    test_table_a("load", 5, en_t, up_t, ld_t, clr_t, lv_t);
  endtask

  task automatic test_priority;
    int en_t[]  = '{0, 1, 1, 0, 1, 1};
    int up_t[]  = '{1, 1, 1, 1, 1, 0};
    int ld_t[]  = '{1, 1, 1, 1, 1, 0};
    int clr_t[] = '{0, 1, 0, 0, 0, 1};
    int lv_t[]  = '{5, 12, 3, 9, 4, 7};
    test_table_a("priority", 6, en_t, up_t, ld_t, clr_t, lv_t);
  endtask

  task automatic test_async_reset;
    drive_a(0, 1, 0, 1, 0);
    tick;
    drive_a(1, 1, 0, 0, 0);
    repeat (7) tick;
    tests++;
    if (a_count !== 4'd7) begin
      fails++;
      $display("FAIL pre_reset_count: got %0d, want 7", a_count);
    end
    a_rst = 1'b0;
    #2;
    tests++;
    if (a_count !== 4'd0 || a_wrap !== 1'b0 || a_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_mid_count: got count=%0d wrap=%0b err=%0b, want 0 0 0", a_count, a_wrap, a_err);
    end
    drive_a(1, 1, 1, 0, 12);
    tick;
    tests++;
    if (a_count !== 4'd0 || a_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_beats_load: got count=%0d err=%0b, want 0 0", a_count, a_err);
    end
    @(negedge clk);
    a_rst = 1'b1;
    drive_a(0, 1, 1, 0, 9);
    tick;
    drive_a(1, 1, 0, 0, 0);
    tick;
    tests++;
    if (a_count !== 4'd0 || a_wrap !== 1'b1) begin
      fails++;
      $display("FAIL wrap_before_reset: got count=%0d wrap=%0b, want 0 1", a_count, a_wrap);
    end
    a_rst = 1'b0;
    #2;
    tests++;
    if (a_wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset_clears_wrap: got wrap=%0b, want 0", a_wrap);
    end
    drive_a(0, 1, 0, 0, 0);
    @(negedge clk);
    a_rst = 1'b1;
    ma = 0;
  endtask

  task automatic test_mod8_b;
    int  en_t[] = '{1, 1, 1, 0, 1, 1};
    int  up_t[] = '{1, 1, 1, 1, 0, 0};
    int  nxt;
    logic [2:0] prev, exp_t, obs_t;
    bit  exp_w, exp_tc;
    for (int k = 0; k < 6; k++) begin
      drive_b(en_t[k][0], up_t[k][0], 0, 0, 0);
      #1;
      exp_tc = ref_tc(mb, MB, en_t[k][0], up_t[k][0], 1'b0, 1'b0);
      tests++;
      if (b_tc !== exp_tc) begin
        fails++;
        $display("FAIL mod8_tc step %0d: got %0b, want %0b", k, b_tc, exp_tc);
      end
      prev  = b_count;
      nxt   = ref_next(mb, MB, en_t[k][0], up_t[k][0], 1'b0, 1'b0, 0);
      exp_w = ref_wrap(mb, nxt, en_t[k][0], up_t[k][0], 1'b0, 1'b0);
      exp_t = 3'(mb) ^ 3'(nxt);
      tick;
      obs_t = prev ^ b_count;
      tests++;
      if (b_count !== 3'(nxt) || b_wrap !== exp_w || obs_t !== exp_t) begin
        fails++;
        $display("FAIL mod8 step %0d: got count=%0d wrap=%0b T=%b, want count=%0d wrap=%0b T=%b",
                 k, b_count, b_wrap, obs_t, nxt, exp_w, exp_t);
      end
      mb = nxt;
    end
  endtask

  task automatic test_random;
    int  r, lv, nxt;
    bit  en_i, up_i, ld_i, clr_i, exp_tc, exp_w, exp_e;
    for (int k = 0; k < 400; k++) begin
      r     = int'($urandom_range(0, 99));
      clr_i = (r < 5);
      ld_i  = (r >= 5) && (r < 17);
      en_i  = ($urandom_range(0, 3) != 0);
      up_i  = ($urandom_range(0, 1) == 1);
      lv    = int'($urandom_range(0, 15));
      drive_a(en_i, up_i, ld_i, clr_i, lv);
      drive_b(en_i, ~up_i, ld_i, clr_i, lv % MB);
      #1;
      exp_tc = ref_tc(ma, MA, en_i, up_i, ld_i, clr_i);
      tests++;
      if (a_tc !== exp_tc) begin
        fails++;
        $display("FAIL rand_tc_a %0d: got %0b, want %0b (count=%0d)", k, a_tc, exp_tc, ma);
      end
      nxt   = ref_next(ma, MA, en_i, up_i, ld_i, clr_i, lv);
      exp_w = ref_wrap(ma, nxt, en_i, up_i, ld_i, clr_i);
      exp_e = ref_err(MA, ld_i, clr_i, lv);
      ma    = nxt;
      nxt   = ref_next(mb, MB, en_i, ~up_i, ld_i, clr_i, lv % MB);
      tick;
      tests++;
      if (a_count !== 4'(ma) || a_wrap !== exp_w || a_err !== exp_e) begin
        fails++;
        $display("FAIL rand_a %0d: got count=%0d wrap=%0b err=%0b, want count=%0d wrap=%0b err=%0b",
                 k, a_count, a_wrap, a_err, ma, exp_w, exp_e);
      end
      exp_w = ref_wrap(mb, nxt, en_i, ~up_i, ld_i, clr_i);
      tests++;
      if (b_count !== 3'(nxt) || b_wrap !== exp_w || b_err !== 1'b0) begin
        fails++;
        $display("FAIL rand_b %0d: got count=%0d wrap=%0b err=%0b, want count=%0d wrap=%0b err=0",
                 k, b_count, b_wrap, b_err, nxt, exp_w);
      end
      mb = nxt;
    end
  endtask

  initial begin
    test_reset;
    test_count_up;
    test_count_down;
    test_load;
    test_priority;
    test_async_reset;
    test_mod8_b;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
